mem_stage_bytelane: RTL
=======================

// Module: mem_stage_bytelane
// PURPOSE
//  Parametrised MEM pipeline stage for the MIPS32 core.
//  - Holds a byte-addressed data RAM with byte/half/word loads and stores (sign- or zero-extended).
//  - Registers the EX->MEM results into the MEM/WB pipeline register.
//  - Supports a pipeline stall and flags misaligned or out-of-range accesses for the hazard/trap logic.
// PARAMETERS
//  DATA_W  32   datapath width; fixed at 32 in this generation, all lane logic assumes 4 bytes
//  ADDR_W  10   word-address bits; RAM depth = 2**ADDR_W words (1024)
//  OP_LW   6'b110000 ... OP_LHU 6'b110111   opcode map, see BEHAVIOUR
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous active-high reset
//  stall         in   1       1 = hold the MEM/WB register and suppress RAM writes
//  valid_ex      in   1       EX/MEM slot holds a real instruction (0 = bubble)
//  IR_ex         in   32      instruction from EX; opcode = IR_ex[31:26]
//  ALU_ex        in   32      effective byte address (ld/st) or ALU result
//  D_ex          in   32      store data (rt)
//  IR_mem        out  32      registered IR
//  ALU_mem       out  32      registered ALU result
//  LMD           out  32      registered load data, extended per opcode
//  valid_mem     out  1       registered valid
//  misalign_mem  out  1       registered misaligned-access flag
//  oor_mem       out  1       registered out-of-range flag
// BEHAVIOUR
//  - Opcode map:
//      110000 LW   110001 SW   110010 LB   110011 SB
//      110100 LH   110101 SH   110110 LBU  110111 LHU
//    Any other opcode is a non-memory instruction.
//  - Address decode:
//      word index = ALU_ex[ADDR_W+1:2]; byte lane = ALU_ex[1:0]; little-endian, lane 0 = bits 7:0.
//      oor = mem op AND ALU_ex[31:ADDR_W+2] != 0.
//      misalign = (H-ops AND ALU_ex[0]) OR (W-ops AND ALU_ex[1:0] != 0).
//  - Store path:
//      Write occurs at the rising edge when valid_ex & store & !stall & !rst & !misalign & !oor.
//      Byte enables: SB writes 1 lane with D_ex[7:0]; SH writes lanes {1,0} or {3,2} with D_ex[15:0];
//      SW writes all 4 lanes. Unselected lanes are unchanged.
//  - Load path:
//      Combinational array read, extracted and extended, then registered into LMD.
//      Load-to-use latency is 1 cycle.
//      LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
//      A store at edge N is visible to a load presented in cycle N+1. Same-word load and store
//      cannot coexist in one slot.
//      LMD = 0 for non-loads, misaligned, out-of-range or invalid slots.
//  - Pipeline register update, every rising edge:
//      rst              : IR_mem, ALU_mem, LMD <= 0; valid_mem, misalign_mem, oor_mem <= 0.
//                         RAM contents are NOT cleared.
//      stall=1, rst=0   : all outputs hold; no RAM write; stall has priority over new data.
//      else             : IR_mem<=IR_ex, ALU_mem<=ALU_ex, valid_mem<=valid_ex,
//                         misalign_mem<=valid_ex&misalign, oor_mem<=valid_ex&oor, LMD per load path.
//  - Reset asserted mid-store: the write is suppressed on that edge.
//  - misalign and oor may both be 1 for the same instruction; both flags are reported.
//  - Bubble (valid_ex=0): no write, flags 0, IR/ALU still pass through.
// TESTING
//  1. SW D=0xA1B2C3D4 @0x10, then LW @0x10 next cycle -> LMD=0xA1B2C3D4 one cycle after the LW.
//  2. After test 1:
//     - LB @0x13 -> 0xFFFFFFA1; LBU @0x13 -> 0x000000A1; LH @0x10 -> 0xFFFFC3D4.
//     - SB 0x55 @0x11, then LW @0x10 -> 0xA1B255D4.
//  3. LW @0x12 -> misalign_mem=1, LMD=0.
//     SH @0x11 -> misalign_mem=1, word @0x10 unchanged.
//  4. ALU_ex=0x00001000 (ADDR_W=10) SW -> oor_mem=1, no RAM write (word @0 unchanged).
//  5. Hold stall=1 for 3 cycles during SW then LW -> outputs frozen, no write.
//     Release stall -> SW then LW complete in order.
//  6. rst=1 on the SW edge -> all outputs 0, later LW of that address returns the prior contents.
//     valid_ex=0 with a store opcode -> no write.

Source files
------------

// File: rtl/mem_stage_bytelane.sv
// MEM pipeline stage: byte-addressed data RAM with byte/half/word loads and stores,
// registered into the MEM/WB slot with misaligned and out-of-range flags.
module mem_stage_bytelane #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 10,
  parameter logic [5:0] OP_LW  = 6'b110000,
  parameter logic [5:0] OP_SW  = 6'b110001,
  parameter logic [5:0] OP_LB  = 6'b110010,
  parameter logic [5:0] OP_SB  = 6'b110011,
  parameter logic [5:0] OP_LH  = 6'b110100,
  parameter logic [5:0] OP_SH  = 6'b110101,
  parameter logic [5:0] OP_LBU = 6'b110110,
  parameter logic [5:0] OP_LHU = 6'b110111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              valid_ex,
  input  logic [DATA_W-1:0] IR_ex,
  input  logic [DATA_W-1:0] ALU_ex,
  input  logic [DATA_W-1:0] D_ex,
  output logic [DATA_W-1:0] IR_mem,
  output logic [DATA_W-1:0] ALU_mem,
  output logic [DATA_W-1:0] LMD,
  output logic              valid_mem,
  output logic              misalign_mem,
  output logic              oor_mem
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] ram_q [0:DEPTH-1];

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              is_load, is_store, is_byte, is_half, is_word;
  logic              misalign, oor, access_ok;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] ir_mem_d, ir_mem_q;
  logic [DATA_W-1:0] alu_mem_d, alu_mem_q;
  logic [DATA_W-1:0] lmd_d, lmd_q;
  logic              valid_mem_d, valid_mem_q;
  logic              misalign_mem_d, misalign_mem_q;
  logic              oor_mem_d, oor_mem_q;

  function automatic logic [3:0] store_be(input logic b, input logic h, input logic [1:0] ln);
    if (b)      return 4'b0001 << ln;
    else if (h) return ln[1] ? 4'b1100 : 4'b0011;
    else        return 4'b1111;
  endfunction

  // Sub-word stores replicate the source across lanes; the byte enables pick the target.
  function automatic logic [DATA_W-1:0] store_data(input logic b, input logic h,
                                                   input logic [DATA_W-1:0] d);
    if (b)      return {4{d[7:0]}};
    else if (h) return {2{d[15:0]}};
    else        return d;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] ln,
                                                    input logic [5:0] op);
    logic [7:0]               b;
    logic [15:0]              h;
    logic signed [7:0]        b_s;
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] ext_s;
    b     = word[{ln, 3'b000} +: 8];
    h     = ln[1] ? word[31:16] : word[15:0];
    b_s   = b;
    h_s   = h;
    ext_s = '0;
    case (op)
      OP_LW:   ext_s = word;
      OP_LB:   ext_s = b_s;
      OP_LH:   ext_s = h_s;
      OP_LBU:  ext_s = {24'd0, b};
      OP_LHU:  ext_s = {16'd0, h};
      default: ext_s = '0;
    endcase
    return ext_s;
  endfunction

  assign opcode   = IR_ex[31:26];
  assign word_idx = ALU_ex[ADDR_W+1:2];
  assign lane     = ALU_ex[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (opcode)
      OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; end
      OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      default: ;
    endcase
  end

  assign oor       = (is_load | is_store) & (|ALU_ex[DATA_W-1:ADDR_W+2]);
  assign misalign  = (is_half & ALU_ex[0]) | (is_word & (|ALU_ex[1:0]));
  assign access_ok = valid_ex & ~misalign & ~oor;

  // Store path: stall and reset both veto the write on this edge
  assign ram_we    = access_ok & is_store & ~stall & ~rst;
  assign ram_be    = store_be(is_byte, is_half, lane);
  assign ram_wdata = store_data(is_byte, is_half, D_ex);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram_q[word_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  // Load path: asynchronous array read, lane extract/extend, registered below
  assign rd_word = ram_q[word_idx];

  always_comb begin
    ir_mem_d       = ir_mem_q;
    alu_mem_d      = alu_mem_q;
    lmd_d          = lmd_q;
    valid_mem_d    = valid_mem_q;
    misalign_mem_d = misalign_mem_q;
    oor_mem_d      = oor_mem_q;
    if (!stall) begin
      ir_mem_d       = IR_ex;
      alu_mem_d      = ALU_ex;
      valid_mem_d    = valid_ex;
      misalign_mem_d = valid_ex & misalign;
      oor_mem_d      = valid_ex & oor;
      lmd_d          = (access_ok & is_load) ? load_extend(rd_word, lane, opcode) : '0;
    end
  end

  // MEM/WB register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_mem_q       <= '0;
      alu_mem_q      <= '0;
      lmd_q          <= '0;
      valid_mem_q    <= 1'b0;
      misalign_mem_q <= 1'b0;
      oor_mem_q      <= 1'b0;
    end else begin
      ir_mem_q       <= ir_mem_d;
      alu_mem_q      <= alu_mem_d;
      lmd_q          <= lmd_d;
      valid_mem_q    <= valid_mem_d;
      misalign_mem_q <= misalign_mem_d;
      oor_mem_q      <= oor_mem_d;
    end
  end

  assign IR_mem       = ir_mem_q;
  assign ALU_mem      = alu_mem_q;
  assign LMD          = lmd_q;
  assign valid_mem    = valid_mem_q;
  assign misalign_mem = misalign_mem_q;
  assign oor_mem      = oor_mem_q;

endmodule
